// File: rtl/semi_auto_ctrl.sv
// ============================================================================
// semi_auto_ctrl : corridor-following sequencer with junction wait/turn logic
// Revision 1.0   : initial release
// ============================================================================
`default_nettype none

module semi_auto_ctrl #(
   parameter int TURN_CYCLES    = 90_000_000,
   parameter int LEAVE_CYCLES   = 30_000_000,
   parameter int CONFIRM_CYCLES = 1_000
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       front_detector,
   input  logic       back_detector,
   input  logic       left_detector,
   input  logic       right_detector,
   input  logic       cmd_forward,
   input  logic       cmd_left,
   input  logic       cmd_right,
   input  logic       cmd_back,
   output logic [3:0] moving_state,
   output logic       waiting,
   output logic [2:0] ctrl_state
);

   localparam int TW = $clog2(2 * TURN_CYCLES + 1);
   localparam int LW = $clog2(LEAVE_CYCLES + 1);
   localparam int CW = $clog2(CONFIRM_CYCLES + 1);

   localparam logic [TW-1:0] TURN_ONE  = TW'(TURN_CYCLES);
   localparam logic [TW-1:0] TURN_TWO  = TW'(2 * TURN_CYCLES);
   localparam logic [LW-1:0] LEAVE_N   = LW'(LEAVE_CYCLES);
   localparam logic [CW-1:0] CONFIRM_N = CW'(CONFIRM_CYCLES);

   localparam logic [3:0] MOVE_STOP  = 4'b0000;
   localparam logic [3:0] MOVE_FWD   = 4'b0001;
   localparam logic [3:0] MOVE_LEFT  = 4'b0100;
   localparam logic [3:0] MOVE_RIGHT = 4'b1000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_TURN   = 3'd2,
      S_LEAVE  = 3'd3,
      S_CRUISE = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_CORRIDOR = 3'd0,
      C_DEAD     = 3'd1,
      C_LEFT     = 3'd2,
      C_RIGHT    = 3'd3,
      C_JUNCTION = 3'd4
   } case_t;

   state_t          state;
   case_t           det_case;
   case_t           last_case;
   logic [TW-1:0]   turn_cnt;
   logic [LW-1:0]   leave_cnt;
   logic [CW-1:0]   conf_cnt;
   logic [CW-1:0]   conf_next;
   logic            confirmed;
   logic            unused_back;

   assign unused_back = back_detector;
   assign ctrl_state  = state;

   always_comb begin
      det_case = C_JUNCTION;
      case ({front_detector, left_detector, right_detector})
         3'b011:  det_case = C_CORRIDOR;
         3'b111:  det_case = C_DEAD;
         3'b101:  det_case = C_LEFT;
         3'b110:  det_case = C_RIGHT;
         default: det_case = C_JUNCTION;
      endcase
   end

   // Run length including the current cycle; a new case starts over at one.
   always_comb begin
      if (det_case != last_case)
         conf_next = CW'(1);
      else if (conf_cnt == {CW{1'b1}})
         conf_next = conf_cnt;
      else
         conf_next = conf_cnt + 1'b1;
      confirmed = (conf_next >= CONFIRM_N);
   end

   always_ff @(posedge sys_clk) begin
      if (rst || !enable) begin
         state        <= S_IDLE;
         moving_state <= MOVE_STOP;
         waiting      <= 1'b0;
         turn_cnt     <= '0;
         leave_cnt    <= '0;
         conf_cnt     <= '0;
         last_case    <= C_CORRIDOR;
      end else begin
         case (state)
            S_IDLE: begin
               state        <= S_WAIT;
               moving_state <= MOVE_STOP;
               waiting      <= 1'b1;
            end
            S_WAIT: begin
               if (cmd_forward) begin
                  state        <= S_LEAVE;
                  leave_cnt    <= LEAVE_N;
                  moving_state <= MOVE_FWD;
                  waiting      <= 1'b0;
               end else if (cmd_left) begin
                  state        <= S_TURN;
                  turn_cnt     <= TURN_ONE;
                  moving_state <= MOVE_LEFT;
                  waiting      <= 1'b0;
               end else if (cmd_right) begin
                  state        <= S_TURN;
                  turn_cnt     <= TURN_ONE;
                  moving_state <= MOVE_RIGHT;
                  waiting      <= 1'b0;
               end else if (cmd_back) begin
                  state        <= S_TURN;
                  turn_cnt     <= TURN_TWO;
                  moving_state <= MOVE_RIGHT;
                  waiting      <= 1'b0;
               end
            end
            S_TURN: begin
               if (turn_cnt <= TW'(1)) begin
                  state        <= S_LEAVE;
                  turn_cnt     <= '0;
                  leave_cnt    <= LEAVE_N;
                  moving_state <= MOVE_FWD;
               end else begin
                  turn_cnt <= turn_cnt - 1'b1;
               end
            end
            S_LEAVE: begin
               if (leave_cnt <= LW'(1)) begin
                  state     <= S_CRUISE;
                  leave_cnt <= '0;
                  conf_cnt  <= '0;
                  last_case <= C_CORRIDOR;
               end else begin
                  leave_cnt <= leave_cnt - 1'b1;
               end
            end
            S_CRUISE: begin
               if (det_case == C_CORRIDOR) begin
                  conf_cnt  <= '0;
                  last_case <= C_CORRIDOR;
               end else if (confirmed) begin
                  conf_cnt  <= '0;
                  last_case <= C_CORRIDOR;
                  case (det_case)
                     C_DEAD: begin
                        state        <= S_TURN;
                        turn_cnt     <= TURN_TWO;
                        moving_state <= MOVE_RIGHT;
                     end
                     C_LEFT: begin
                        state        <= S_TURN;
                        turn_cnt     <= TURN_ONE;
                        moving_state <= MOVE_LEFT;
                     end
                     C_RIGHT: begin
                        state        <= S_TURN;
                        turn_cnt     <= TURN_ONE;
                        moving_state <= MOVE_RIGHT;
                     end
                     default: begin
                        state        <= S_WAIT;
                        moving_state <= MOVE_STOP;
                        waiting      <= 1'b1;
                     end
                  endcase
               end else begin
                  conf_cnt  <= conf_next;
                  last_case <= det_case;
               end
            end
            default: begin
               state        <= S_IDLE;
               moving_state <= MOVE_STOP;
               waiting      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_semi_auto_ctrl.sv
// ============================================================================
// tb_semi_auto_ctrl : directed and randomized checks against a cycle-count model
// Revision 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_semi_auto_ctrl;

   localparam int T = 8;
   localparam int L = 4;
   localparam int C = 2;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       front_detector = 1'b0;
   logic       back_detector = 1'b0;
   logic       left_detector = 1'b1;
   logic       right_detector = 1'b1;
   logic       cmd_forward = 1'b0;
   logic       cmd_left = 1'b0;
   logic       cmd_right = 1'b0;
   logic       cmd_back = 1'b0;
   logic [3:0] moving_state;
   logic       waiting;
   logic [2:0] ctrl_state;

   always #5 sys_clk = ~sys_clk;

   semi_auto_ctrl #(
      .TURN_CYCLES    (T),
      .LEAVE_CYCLES   (L),
      .CONFIRM_CYCLES (C)
   ) dut (
      .sys_clk        (sys_clk),
      .rst            (rst),
      .enable         (enable),
      .front_detector (front_detector),
      .back_detector  (back_detector),
      .left_detector  (left_detector),
      .right_detector (right_detector),
      .cmd_forward    (cmd_forward),
      .cmd_left       (cmd_left),
      .cmd_right      (cmd_right),
      .cmd_back       (cmd_back),
      .moving_state   (moving_state),
      .waiting        (waiting),
      .ctrl_state     (ctrl_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: state name, absolute cycle at which a timed state ends,
   // and the list of consecutive non-corridor cases seen in CRUISE.
   int m_state = 0;
   int m_until = 0;
   bit m_right = 1'b0;
   int hist[$];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // 0 corridor, 1 dead end, 2 turn left, 3 turn right, 4 junction -> wait
   function automatic int classify(bit f, bit l, bit r);
      if (!f && l && r) return 0;
      if (f && l && r)  return 1;
      if (f && !l && r) return 2;
      if (f && l && !r) return 3;
      return 4;
   endfunction

   function automatic int exp_moving();
      case (m_state)
         2:       return m_right ? 8 : 4;
         3, 4:    return 1;
         default: return 0;
      endcase
   endfunction

   task automatic start_turn(input bit right, input int n);
      m_state = 2;
      m_right = right;
      m_until = cyc + n;
   endtask

   task automatic start_leave();
      m_state = 3;
      m_until = cyc + L;
   endtask

   task automatic model_edge();
      int k;
      cyc++;
      if (rst || !enable) begin
         m_state = 0;
         m_right = 1'b0;
         hist.delete();
      end else begin
         case (m_state)
            0: m_state = 1;
            1: begin
               if (cmd_forward)    start_leave();
               else if (cmd_left)  start_turn(1'b0, T);
               else if (cmd_right) start_turn(1'b1, T);
               else if (cmd_back)  start_turn(1'b1, 2 * T);
            end
            2: if (cyc == m_until) start_leave();
            3: if (cyc == m_until) begin
               m_state = 4;
               hist.delete();
            end
            default: begin
               k = classify(front_detector, left_detector, right_detector);
               if (k == 0) begin
                  hist.delete();
               end else begin
                  if (hist.size() > 0 && hist[$] != k) hist.delete();
                  hist.push_back(k);
                  if (hist.size() >= C) begin
                     hist.delete();
                     case (k)
                        1:       start_turn(1'b1, 2 * T);
                        2:       start_turn(1'b0, T);
                        3:       start_turn(1'b1, T);
                        default: m_state = 1;
                     endcase
                  end
               end
            end
         endcase
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      model_edge();
      #1;
      check("state", int'(ctrl_state), m_state);
      check("moving", int'(moving_state), exp_moving());
      check("waiting", int'(waiting), (m_state == 1) ? 1 : 0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic set_det(input bit f, input bit l, input bit r);
      front_detector = f;
      left_detector  = l;
      right_detector = r;
   endtask

   task automatic clear_cmds();
      cmd_forward = 1'b0;
      cmd_left    = 1'b0;
      cmd_right   = 1'b0;
      cmd_back    = 1'b0;
   endtask

   initial begin
      steps(3);
      rst = 1'b0;
      step();
      check("reset_moving", int'(moving_state), 0);
      check("reset_state", int'(ctrl_state), 0);
      check("reset_waiting", int'(waiting), 0);

      // Enabled without a command: wait indefinitely
      enable = 1'b1;
      steps(20);
      check("wait_hold_state", int'(ctrl_state), 1);
      check("wait_hold_waiting", int'(waiting), 1);

      // Left beats right in the same cycle
      cmd_left = 1'b1;
      cmd_right = 1'b1;
      step();
      clear_cmds();
      check("cmd_lr_turn", int'(moving_state), 4'b0100);
      steps(7);
      check("turn_left_last", int'(moving_state), 4'b0100);
      step();
      check("turn_to_leave", int'(moving_state), 4'b0001);
      steps(3);
      check("leave_last", int'(ctrl_state), 3);
      step();
      check("leave_to_cruise", int'(ctrl_state), 4);

      // One-cycle front glitch is ignored
      set_det(1, 1, 1);
      step();
      set_det(0, 1, 1);
      steps(5);
      check("glitch_ignored", int'(ctrl_state), 4);

      // Front blocked, left clear: auto left turn after confirmation
      set_det(1, 0, 1);
      step();
      check("confirm_pending", int'(ctrl_state), 4);
      step();
      check("auto_left", int'(moving_state), 4'b0100);
      set_det(0, 1, 1);
      steps(T + L);
      check("back_to_cruise", int'(ctrl_state), 4);

      // Dead end: 180 degree right turn
      set_det(1, 1, 1);
      steps(2);
      check("dead_end_turn", int'(moving_state), 4'b1000);
      set_det(0, 1, 1);
      steps(2 * T - 1);
      check("dead_end_last", int'(moving_state), 4'b1000);
      step();
      check("dead_end_done", int'(moving_state), 4'b0001);
      steps(L);

      // Junction on the right -> wait, then back command with an ignored forward
      set_det(0, 1, 0);
      steps(2);
      check("junction_wait", int'(waiting), 1);
      set_det(0, 1, 1);
      cmd_back = 1'b1;
      step();
      clear_cmds();
      steps(3);
      cmd_forward = 1'b1;
      step();
      clear_cmds();
      check("fwd_ignored_in_turn", int'(moving_state), 4'b1000);
      steps(2 * T - 5);
      check("back_turn_last", int'(moving_state), 4'b1000);
      steps(L + 2);

      // Abort a turn with enable, then with rst
      set_det(0, 0, 1);
      steps(2);
      cmd_left = 1'b1;
      step();
      clear_cmds();
      steps(3);
      enable = 1'b0;
      step();
      check("abort_enable_moving", int'(moving_state), 0);
      check("abort_enable_state", int'(ctrl_state), 0);
      enable = 1'b1;
      step();
      check("reenable_wait", int'(ctrl_state), 1);
      cmd_right = 1'b1;
      step();
      clear_cmds();
      steps(3);
      rst = 1'b1;
      step();
      check("abort_rst_moving", int'(moving_state), 0);
      rst = 1'b0;
      step();
      check("rst_restart_wait", int'(ctrl_state), 1);
      check("rst_restart_moving", int'(moving_state), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst    = ($urandom_range(0, 299) == 0);
         enable = ($urandom_range(0, 149) != 0);
         cmd_forward = ($urandom_range(0, 11) == 0);
         cmd_left    = ($urandom_range(0, 11) == 0);
         cmd_right   = ($urandom_range(0, 11) == 0);
         cmd_back    = ($urandom_range(0, 11) == 0);
         back_detector = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) set_det(0, 1, 1);
            else set_det($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
